// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus a carry-in,
// one bit per clock (LSB first) through a single gate-level full adder.
// Results (sum, carryout, overflow) are registered and held after the done pulse.

// Gate-level full adder cell shared by the serial datapath.
module structuralFullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic p_s;
    logic g_s;
    logic t_s;

    xor u_x1 (p_s, a, b);
    xor u_x2 (sum, p_s, cin);
    and u_a1 (g_s, a, b);
    and u_a2 (t_s, p_s, cin);
    or  u_o1 (cout, g_s, t_s);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              cmsb_q, cmsb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              fa_sum_s;
    logic              fa_cout_s;

    // The only adder in the datapath: operates on the current LSBs and carry.
    structuralFullAdder u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next-state and datapath update; every register holds unless its phase says otherwise.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = carryin;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = {fa_sum_s, acc_q[WIDTH-1:1]};
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                carry_d = fa_cout_s;
                // Carry leaving bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_PENULT) begin
                    cmsb_d = fa_cout_s;
                end else begin
                    cmsb_d = cmsb_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = {CW{1'b0}};
                    done_d  = 1'b1;
                    cout_d  = fa_cout_s;
                    ovf_d   = cmsb_q ^ fa_cout_s;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = acc_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8, clock period 400).
// A cycle-indexed behavioural model predicts busy/done windows and results.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carryin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout),
        .overflow (overflow)
    );

    always #200 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {ovf, carryout, sum} from plain arithmetic and the sign rule.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        logic       ov;
        r  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {ov, r};
    endfunction

    // Model state: edge index of the last accepted operation and the held results.
    int            cyc = 0;
    int            acc_cyc = -1000;
    logic [W+1:0]  pend = '0;
    logic [W+1:0]  held = '0;

    // Behavioural model: accept when at least W+2 edges since last accept; publish at done.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_cyc <= -1000;
            pend    <= '0;
            held    <= '0;
        end else begin
            cyc <= cyc + 1;
            if (start && (cyc - acc_cyc >= W + 2)) begin
                acc_cyc <= cyc;
                pend    <= ref_add(a, b, carryin);
            end
            if (cyc == acc_cyc + W) begin
                held <= pend;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(carryout), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
        end else begin
            logic exp_busy;
            logic exp_done;
            exp_busy = (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + W);
            exp_done = (cyc == acc_cyc + W + 1);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("cout", 32'(carryout), 32'(held[W]));
            chk("ovf", 32'(overflow), 32'(held[W+1]));
            if (!exp_busy) begin
                chk("sum", 32'(sum), 32'(held[W-1:0]));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // One operation with expected results; checks done latency and result values.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W-1:0] es, input logic eco, input logic eov, input string nm);
        int n;
        wait_idle();
        a = ta; b = tb; carryin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); carryin = 1'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'd9);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(carryout), 32'(eco));
        chk({nm, "_ovf"}, 32'(overflow), 32'(eov));
    endtask

    initial begin
        int ndone;
        int pos[$];
        logic [W-1:0] got;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W+1:0] r;
        logic [W-1:0] corners [5];

        #1;
        chk("por_busy", 32'(busy), 32'd0);
        chk("por_sum", 32'(sum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Hand-computed cases.
        op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "d3c0f");
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "dff01");
        op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "d00c1");
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "d7f01");
        op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "d8080");

        // Start pulsed during RUN must be ignored.
        wait_idle();
        a = 8'h3C; b = 8'h0F; carryin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0; got = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin ndone++; got = sum; end
            @(negedge clk);
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_sum", 32'(got), 32'h4B);

        // Asynchronous reset between edges aborts the operation.
        wait_idle();
        a = 8'h3C; b = 8'h0F; carryin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #100 reset = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_sum", 32'(sum), 32'd0);
        chk("mid_cout", 32'(carryout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_ndone", 32'(ndone), 32'd0);
        op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "post_rst");

        // Start held high: back-to-back operations every W+2 cycles.
        wait_idle();
        a = 8'h55; b = 8'h2A; carryin = 1'b1; start = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done) begin
                pos.push_back(i);
                chk("b2b_sum", 32'(sum), 32'h80);
                chk("b2b_ovf", 32'(overflow), 32'd1);
            end
        end
        start = 1'b0;
        if (pos.size() >= 3) begin
            chk("b2b_gap1", 32'(pos[1] - pos[0]), 32'd10);
            chk("b2b_gap2", 32'(pos[2] - pos[1]), 32'd10);
        end else begin
            chk("b2b_count", 32'(pos.size()), 32'd3);
        end

        // Corner operand grid.
        corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
        corners[3] = 8'h80; corners[4] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                for (int k = 0; k < 2; k++) begin
                    r = ref_add(corners[i], corners[j], 1'(k));
                    op(corners[i], corners[j], 1'(k), r[W-1:0], r[W], r[W+1], "corner");
                end
            end
        end

        // Randomized operations.
        for (int i = 0; i < 1200; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            r  = ref_add(ra, rb, rc);
            op(ra, rb, rc, r[W-1:0], r[W], r[W+1], "rand");
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
